// File: rtl/bist_pattern_engine.sv
// BIST engine: LFSR stimulus generator and 16-bit serial MISR compactor for a small sequential CUT.
// Defining BIST_ABORT_EN adds an abort input that cancels a test in FLUSH or RUN.
module bist_pattern_engine #(
  parameter int              N_IN         = 4,
  parameter logic [7:0]      LFSR_SEED    = 8'h01,
  parameter int              FLUSH_CYCLES = 4,
  parameter logic [N_IN-1:0] FLUSH_PAT    = '0,
  parameter int              PATTERNS     = 255,
  parameter logic [15:0]     MISR_SEED    = 16'h0000,
  parameter logic [15:0]     GOLDEN       = 16'h0000
) (
  input  logic            CK,
  input  logic            RN,
  input  logic            start,
`ifdef BIST_ABORT_EN
  input  logic            abort,
`endif
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature
);

  // state | meaning
  // IDLE  | waiting for start, stim parked at FLUSH_PAT
  // FLUSH | driving FLUSH_PAT to clear the unreset CUT flops, resp ignored
  // RUN   | driving LFSR patterns, MISR compacting resp
  // DONE  | one-cycle done pulse, pass/signature final
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] PAT_LAST   = 16'(PATTERNS - 1);
  localparam logic [15:0] MISR_POLY  = 16'h1021;

  state_t      state, next_state;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_nxt;
  logic [15:0] misr;
  logic [15:0] misr_nxt;
  logic [15:0] cnt;
  logic        abort_hit;
  logic        flush_last;
  logic        run_last;

`ifdef BIST_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign lfsr_nxt   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign misr_nxt   = {misr[14:0], 1'b0} ^ ((misr[15] ^ resp) ? MISR_POLY : 16'h0000);
  assign flush_last = (cnt == FLUSH_LAST);
  assign run_last   = (cnt == PAT_LAST);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = FLUSH;
      end
      FLUSH: begin
        if (abort_hit)       next_state = IDLE;
        else if (flush_last) next_state = RUN;
      end
      RUN: begin
        if (abort_hit)     next_state = IDLE;
        else if (run_last) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One shared up-counter: flush cycles first, then compacted patterns.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      lfsr <= LFSR_SEED;
      misr <= 16'h0000;
      cnt  <= 16'h0000;
      stim <= FLUSH_PAT;
      pass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lfsr <= LFSR_SEED;
            misr <= MISR_SEED;
            cnt  <= 16'h0000;
            pass <= 1'b0;
            stim <= FLUSH_PAT;
          end
        end
        FLUSH: begin
          if (abort_hit) begin
            stim <= FLUSH_PAT;
          end else if (flush_last) begin
            cnt  <= 16'h0000;
            stim <= lfsr[N_IN-1:0];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RUN: begin
          if (abort_hit) begin
            // Partial signature is kept for debug; the aborting edge does not compact.
            stim <= FLUSH_PAT;
          end else begin
            misr <= misr_nxt;
            lfsr <= lfsr_nxt;
            cnt  <= cnt + 16'd1;
            if (run_last) begin
              stim <= FLUSH_PAT;
              pass <= (misr_nxt == GOLDEN);
            end else begin
              stim <= lfsr_nxt[N_IN-1:0];
            end
          end
        end
        DONE: begin
          stim <= FLUSH_PAT;
        end
        default: begin
          stim <= FLUSH_PAT;
        end
      endcase
    end
  end

  assign busy      = (state == FLUSH) || (state == RUN);
  assign done      = (state == DONE);
  assign signature = misr;

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Directed self-checking bench for bist_pattern_engine using four differently parameterised instances.
`timescale 1ns/1ps
module tb_bist_pattern_engine;

  logic CK = 1'b0;
  logic RN = 1'b0;

  logic start = 1'b0, start_fail = 1'b0, start_one = 1'b0, start_two = 1'b0;
  logic resp = 1'b0, resp_fail = 1'b0, resp_one = 1'b0, resp_two = 1'b0;
  logic abort = 1'b0;
  logic abort_off = 1'b0;

  logic [3:0]  stim, stim_fail, stim_one, stim_two;
  logic        busy, busy_fail, busy_one, busy_two;
  logic        done, done_fail, done_one, done_two;
  logic        pass, pass_fail, pass_one, pass_two;
  logic [15:0] sig, sig_fail, sig_one, sig_two;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CK = ~CK;

  bist_pattern_engine dut (
    .CK(CK), .RN(RN), .start(start),
`ifdef BIST_ABORT_EN
    .abort(abort),
`endif
    .stim(stim), .resp(resp), .busy(busy), .done(done), .pass(pass), .signature(sig)
  );

  bist_pattern_engine #(.GOLDEN(16'h0001)) dut_fail (
    .CK(CK), .RN(RN), .start(start_fail),
`ifdef BIST_ABORT_EN
    .abort(abort_off),
`endif
    .stim(stim_fail), .resp(resp_fail), .busy(busy_fail), .done(done_fail), .pass(pass_fail),
    .signature(sig_fail)
  );

  bist_pattern_engine #(.PATTERNS(1), .MISR_SEED(16'h0000)) dut_one (
    .CK(CK), .RN(RN), .start(start_one),
`ifdef BIST_ABORT_EN
    .abort(abort_off),
`endif
    .stim(stim_one), .resp(resp_one), .busy(busy_one), .done(done_one), .pass(pass_one),
    .signature(sig_one)
  );

  bist_pattern_engine #(.PATTERNS(2), .MISR_SEED(16'h8000), .GOLDEN(16'h3063)) dut_two (
    .CK(CK), .RN(RN), .start(start_two),
`ifdef BIST_ABORT_EN
    .abort(abort_off),
`endif
    .stim(stim_two), .resp(resp_two), .busy(busy_two), .done(done_two), .pass(pass_two),
    .signature(sig_two)
  );

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (stim !== 4'h0) $display("FAIL reset_stim got %h exp 0", stim); else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b exp 00", busy, done);
    else n_pass++;
    n_checks++;
    if (pass !== 1'b0 || sig !== 16'h0000) $display("FAIL reset_pass_sig got %b %h exp 0 0000", pass, sig);
    else n_pass++;
    tick();
    tick();
    RN = 1'b1;
    tick();
  endtask

  task automatic test_lfsr();
    logic [3:0] exp_stim [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2};
    int edges;
    resp  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || stim !== 4'h0) $display("FAIL lfsr_flush0 got busy=%b stim=%h exp 1 0", busy, stim);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (stim !== 4'h0) $display("FAIL lfsr_flush%0d got %h exp 0", i + 1, stim); else n_pass++;
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (stim !== exp_stim[i]) $display("FAIL lfsr_run%0d got %h exp %h", i, stim, exp_stim[i]);
      else n_pass++;
    end
    edges = 0;
    while (done !== 1'b1 && edges < 400) begin tick(); edges++; end
    tick();
  endtask

  task automatic test_pass();
    int edges;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (done !== 1'b1 && edges < 400) begin tick(); edges++; end
    n_checks++;
    if (edges !== 260) $display("FAIL pass_latency got %0d exp 260", edges); else n_pass++;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL pass_done got done=%b busy=%b exp 1 0", done, busy);
    else n_pass++;
    n_checks++;
    if (sig !== 16'h0000 || pass !== 1'b1) $display("FAIL pass_result got %h %b exp 0000 1", sig, pass);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0 || pass !== 1'b1 || sig !== 16'h0000)
      $display("FAIL pass_hold got done=%b pass=%b sig=%h exp 0 1 0000", done, pass, sig);
    else n_pass++;
  endtask

  task automatic test_fail();
    int edges;
    resp_fail  = 1'b0;
    start_fail = 1'b1;
    tick();
    start_fail = 1'b0;
    edges = 1;
    while (done_fail !== 1'b1 && edges < 400) begin tick(); edges++; end
    n_checks++;
    if (edges !== 260) $display("FAIL fail_latency got %0d exp 260", edges); else n_pass++;
    n_checks++;
    if (sig_fail !== 16'h0000 || pass_fail !== 1'b0)
      $display("FAIL fail_result got %h %b exp 0000 0", sig_fail, pass_fail);
    else n_pass++;
    tick();
  endtask

  task automatic test_single();
    int edges;
    resp_one  = 1'b1;
    start_one = 1'b1;
    tick();
    start_one = 1'b0;
    edges = 1;
    while (done_one !== 1'b1 && edges < 50) begin tick(); edges++; end
    n_checks++;
    if (edges !== 6) $display("FAIL single_latency got %0d exp 6", edges); else n_pass++;
    n_checks++;
    if (sig_one !== 16'h1021 || pass_one !== 1'b0)
      $display("FAIL single_sig got %h %b exp 1021 0", sig_one, pass_one);
    else n_pass++;
    tick();
  endtask

  task automatic test_misr_seed();
    int edges;
    resp_two  = 1'b0;
    start_two = 1'b1;
    tick();
    start_two = 1'b0;
    repeat (5) tick();
    resp_two = 1'b1;
    edges = 6;
    while (done_two !== 1'b1 && edges < 50) begin tick(); edges++; end
    resp_two = 1'b0;
    n_checks++;
    if (edges !== 7) $display("FAIL seed_latency got %0d exp 7", edges); else n_pass++;
    n_checks++;
    if (sig_two !== 16'h3063 || pass_two !== 1'b1)
      $display("FAIL seed_sig got %h %b exp 3063 1", sig_two, pass_two);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int edges;
    resp_one  = 1'b1;
    start_one = 1'b1;
    tick();
    start_one = 1'b0;
    edges = 1;
    while (done_one !== 1'b1 && edges < 50) begin tick(); edges++; end
    start_one = 1'b1;
    tick();
    n_checks++;
    if (busy_one !== 1'b0 || sig_one !== 16'h1021)
      $display("FAIL b2b_ignored_in_done got busy=%b sig=%h exp 0 1021", busy_one, sig_one);
    else n_pass++;
    tick();
    start_one = 1'b0;
    resp_one  = 1'b0;
    n_checks++;
    if (busy_one !== 1'b1 || pass_one !== 1'b0)
      $display("FAIL b2b_accept got busy=%b pass=%b exp 1 0", busy_one, pass_one);
    else n_pass++;
    edges = 1;
    while (done_one !== 1'b1 && edges < 50) begin tick(); edges++; end
    n_checks++;
    if (edges !== 6 || sig_one !== 16'h0000 || pass_one !== 1'b1)
      $display("FAIL b2b_second got edges=%0d sig=%h pass=%b exp 6 0000 1", edges, sig_one, pass_one);
    else n_pass++;
    tick();
  endtask

  task automatic test_start_busy();
    int edges;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (done !== 1'b1 && edges < 400) begin
      tick();
      edges++;
      start = (edges == 15);
    end
    start = 1'b0;
    n_checks++;
    if (edges !== 260) $display("FAIL busy_start_latency got %0d exp 260", edges); else n_pass++;
    n_checks++;
    if (pass !== 1'b1 || sig !== 16'h0000) $display("FAIL busy_start_result got %b %h exp 1 0000", pass, sig);
    else n_pass++;
    tick();
  endtask

`ifdef BIST_ABORT_EN
  task automatic test_abort();
    logic seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stim !== 4'h0)
      $display("FAIL abort_run got busy=%b done=%b stim=%h exp 0 0 0", busy, done, stim);
    else n_pass++;
    n_checks++;
    if (pass !== 1'b0 || sig !== 16'h0000) $display("FAIL abort_result got %b %h exp 0 0000", pass, sig);
    else n_pass++;
    seen = 1'b0;
    repeat (300) begin tick(); seen |= done; end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL abort_no_done got %b exp 0", seen); else n_pass++;
    abort = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL abort_idle_ignored got busy=%b exp 1", busy); else n_pass++;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abort_flush got busy=%b exp 0", busy); else n_pass++;
    tick();
  endtask
`endif

  task automatic test_reset_midrun();
    logic seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rst_pre_busy got %b exp 1", busy); else n_pass++;
    #3;
    RN = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stim !== 4'h0)
      $display("FAIL rst_async got busy=%b done=%b stim=%h exp 0 0 0", busy, done, stim);
    else n_pass++;
    n_checks++;
    if (sig_two !== 16'h0000 || pass_two !== 1'b0)
      $display("FAIL rst_async_held got sig=%h pass=%b exp 0000 0", sig_two, pass_two);
    else n_pass++;
    tick();
    RN = 1'b1;
    seen = 1'b0;
    repeat (300) begin tick(); seen |= done; end
    n_checks++;
    if (seen !== 1'b0 || busy !== 1'b0) $display("FAIL rst_no_done got done_seen=%b busy=%b exp 0 0", seen, busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lfsr();
    test_pass();
    test_fail();
    test_single();
    test_misr_seed();
    test_back_to_back();
    test_start_busy();
`ifdef BIST_ABORT_EN
    test_abort();
`endif
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bist_pattern_engine.md
# bist_pattern_engine

Built-in self-test driver and observer for a small sequential benchmark core with 4 primary inputs and 1 primary output. Drives the core's inputs and compacts its output.
- Inputs come from an LFSR pattern generator.
- The output is compacted into a MISR signature, which is compared against a golden value.
- Sits between the test controller and the core under test (CUT); the CUT's flip-flops have no reset, so the engine flushes them with a fixed pattern before compaction starts.

## Interface
- N_IN, 4, stimulus width driven to CUT (must be ≤ 8)
- LFSR_SEED, 8'h01, LFSR load value at start; must be nonzero
- FLUSH_CYCLES, 4, cycles of fixed pattern applied before compaction (≥ 1)
- FLUSH_PAT, 4'b0000, stimulus value during flush
- PATTERNS, 255, number of compacted pattern cycles (1..65535)
- MISR_SEED, 16'h0000, MISR load value at start
- GOLDEN, 16'h0000, expected signature

Ports:
- CK  in  1  clock, rising edge
- RN  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a test; honoured only in IDLE
- stim  out  N_IN  stimulus to CUT primary inputs (registered)
- resp  in  1  CUT primary output
- busy  out  1  high in FLUSH and RUN
- done  out  1  one-cycle pulse when the signature is final
- pass  out  1  signature == GOLDEN; valid from done, held until next start
- signature  out  16  MISR value; held after done until next start

## Operation
- FSM states: IDLE, FLUSH, RUN, DONE.
- IDLE + start → FLUSH on the same edge.
  - That edge loads the LFSR with LFSR_SEED, the MISR with MISR_SEED, and the flush counter with 0.
  - It also clears pass.
- FLUSH:
  - stim = FLUSH_PAT; resp is ignored.
  - After FLUSH_CYCLES cycles → RUN.
- RUN:
  - stim = lfsr[N_IN-1:0].
  - Each edge: MISR captures resp, then the LFSR advances.
  - After PATTERNS cycles → DONE.
- DONE, one cycle:
  - done = 1, pass = (misr == GOLDEN), then → IDLE.
- LFSR is 8-bit Fibonacci: fb = l[7]^l[5]^l[4]^l[3]; l ← {l[6:0], fb}. Period 255.
- MISR is 16-bit serial, CRC-CCITT: fb = m[15]^resp; m ← (m<<1) ^ (fb ? 16'h1021 : 0).
- start while busy or in DONE: ignored, with no effect on state, counters, or outputs.
- stim is driven from registers; in IDLE it holds FLUSH_PAT.
- The pattern counter is 16-bit and does not wrap within a run.

## Timing
- Reset (RN low) values:
  - state IDLE, stim = FLUSH_PAT, busy = 0, done = 0, pass = 0, signature = 0.
  - LFSR = LFSR_SEED, MISR = 0.
- Reset asserted mid-run aborts immediately; no done pulse is produced.
- start sampled at edge E0:
  - busy = 1 from E0 through the last RUN cycle.
  - First flush stimulus is visible after E0.
  - First RUN stimulus is visible after E0+FLUSH_CYCLES.
- resp is sampled at the edge ending each RUN cycle.
  - The CUT path from stim to resp must settle within one cycle.
- done rises after edge E0+FLUSH_CYCLES+PATTERNS, for exactly 1 cycle.
  - Total latency from start to done = FLUSH_CYCLES+PATTERNS+1 edges.
- A new start is accepted in the cycle after done, i.e. back-to-back tests are allowed.

## Configuration
- BIST_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort high at any edge in FLUSH or RUN → IDLE on that edge; busy falls.
  - No done pulse; pass stays 0; signature holds the partial MISR value.
  - abort in IDLE or DONE is ignored.
- Undefined: no abort port; a test always runs to DONE unless RN is asserted.

## Test plan
- Reset:
  - Stimulus: RN low mid-RUN.
  - Required response: all outputs at reset values immediately (asynchronous); no done pulse after RN releases.
- LFSR sequence:
  - Stimulus: defaults, resp = 0, start.
  - Required response: 4 cycles of stim = 0, then RUN stim = 1, 2, 4, 8, 1 (LFSR 01, 02, 04, 08, 11) for the first 5 RUN cycles.
- Pass case:
  - Stimulus: defaults, resp tied 0.
  - Required response: done pulses 260 cycles after start; signature = 16'h0000, pass = 1.
- Fail case:
  - Stimulus: GOLDEN = 16'h0001, resp tied 0.
  - Required response: signature = 16'h0000, pass = 0.
- Single-fault sensitivity:
  - Stimulus: PATTERNS = 1, MISR_SEED = 0, resp = 1 in the only RUN cycle.
  - Required response: signature = 16'h1021.
- Start while busy, and abort:
  - Stimulus: start pulsed during RUN.
  - Required response: ignored; done timing unchanged.
  - Stimulus (with BIST_ABORT_EN): abort in the 10th RUN cycle.
  - Required response: IDLE next cycle; busy = 0, no done pulse.
